// File: rtl/bit4_divider_pkg.sv
// Shared definitions for the restoring divider.
//   WIDTH_DEFAULT : default operand/result width
//   state_t       : controller states (IDLE, CALC, DONE)
//   DBZ_QUOTIENT  : quotient reported on divide-by-zero (all ones); users
//                   take the low WIDTH bits they need
package bit4_divider_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bit4_subtractor.sv
// Combinational ripple-borrow subtractor built from full-adder cells.
//   full_adder      : one-bit full adder cell (a, b, cin -> sum, cout)
//   bit4_subtractor : diff = a - b over W bits, borrow = 1 when a < b.
//                     Implemented as a + ~b + 1, so borrow is the inverted
//                     final carry.
//   Ports: a [W-1:0], b [W-1:0] in; diff [W-1:0], borrow out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module bit4_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/bit4_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin a division (only acted on in IDLE)
//   A, B   : unsigned dividend / divisor
//   busy   : high while iterating
//   done   : one-cycle pulse; Q/R/dbz valid from this cycle on
//   Q, R   : quotient / remainder, held until the next completion
//   dbz    : last completed operation had B == 0
module bit4_divider
  import bit4_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DBZ_Q     = DBZ_QUOTIENT[WIDTH-1:0];

  state_t           state, state_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  logic [2*WIDTH:0] pair_shl;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             qbit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             accept;
  logic             last_iter;

  // armed stays low through the first edge after reset release, so a start
  // that rises together with rst_n is not taken on that edge.
  assign accept    = (state == IDLE) && start && armed;
  assign last_iter = (cnt == LAST_ITER);

  // One restoring step: shift the remainder/dividend pair left, try to
  // subtract the divisor, keep the difference only when it did not borrow.
  // The quotient bit lands in the vacated dividend LSB, so after WIDTH
  // steps dvd holds the quotient.
  always_comb begin
    pair_shl = {rem, dvd} << 1;
    shifted  = pair_shl[2*WIDTH:WIDTH];
    qbit     = ~borrow;
    rem_nxt  = borrow ? shifted : trial;
    dvd_nxt  = pair_shl[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, qbit};
  end

  bit4_subtractor #(
    .W (WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dsr}),
    .diff   (trial),
    .borrow (borrow)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (B == '0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      rem   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      dbz   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (B == '0) begin
              Q   <= DBZ_Q;
              R   <= A;
              dbz <= 1'b1;
            end else begin
              dvd <= A;
              dsr <= B;
              rem <= '0;
              cnt <= '0;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            Q   <= dvd_nxt;
            R   <= rem_nxt[WIDTH-1:0];
            dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit4_divider.sv
// Self-checking bench for bit4_divider with a quotient/remainder model
// computed directly with / and %.
module tb_bit4_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, dbz;
  logic [W-1:0] Q, R;

  int n_cmp  = 0;
  int n_fail = 0;

  bit4_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  // Reference: {Q, R, dbz}
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == 0) return {{W{1'b1}}, a, 1'b1};
    q = a / b;
    r = a % b;
    return {q, r, 1'b0};
  endfunction

  // Edges from the one right after start is driven up to the one after
  // which done is seen high.
  function automatic int exp_lat(input logic [W-1:0] b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  // Issue one operation and wait for done; operands are scrambled right
  // after acceptance to show they are not looked at again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W:0] res, output int lat,
                        output int busy_n, output int overlap, output bit to);
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    lat = 0; busy_n = 0; overlap = 0; to = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (lat == 0) begin A = ~a; B = W'($urandom); end
      lat++;
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) break;
      if (lat > 40) begin to = 1'b1; break; end
    end
    res = {Q, R, dbz};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl busy/done=%b want 00", {busy, done}); end
    n_cmp++;
    if ({Q, R, dbz} !== '0) begin n_fail++; $display("FAIL reset_data Q=%0d R=%0d dbz=%0b want 0", Q, R, dbz); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, Q, R, dbz} !== '0) begin n_fail++; $display("FAIL reset_release busy=%0b done=%0b Q=%0d R=%0d dbz=%0b want 0", busy, done, Q, R, dbz); end
  endtask

  task automatic test_basic();
    logic [2*W:0] res; int lat, bn, ov; bit to;
    run_op(4'd13, 4'd3, res, lat, bn, ov, to);
    n_cmp++;
    if (to || res !== model(4'd13, 4'd3)) begin n_fail++; $display("FAIL basic_13_3 got %h want %h to=%0b", res, model(4'd13, 4'd3), to); end
    n_cmp++;
    if (lat !== exp_lat(4'd3)) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, exp_lat(4'd3)); end
    n_cmp++;
    if (bn !== W) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want %0d", bn, W); end
    n_cmp++;
    if (ov !== 0) begin n_fail++; $display("FAIL basic_busy_done_overlap got %0d want 0", ov); end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL basic_done_pulse busy/done=%b want 00", {busy, done}); end
    n_cmp++;
    if ({Q, R, dbz} !== model(4'd13, 4'd3)) begin n_fail++; $display("FAIL basic_hold got %h want %h", {Q, R, dbz}, model(4'd13, 4'd3)); end
  endtask

  task automatic test_directed();
    logic [2*W-1:0] pairs [6] = '{8'hF1, 8'hFF, 8'h37, 8'h05, 8'h11, 8'hE4};
    logic [2*W:0] res; int lat, bn, ov; bit to;
    logic [W-1:0] a, b;
    foreach (pairs[i]) begin
      a = pairs[i][2*W-1:W];
      b = pairs[i][W-1:0];
      run_op(a, b, res, lat, bn, ov, to);
      n_cmp++;
      if (to || res !== model(a, b) || lat !== exp_lat(b)) begin
        n_fail++;
        $display("FAIL directed_%0d_%0d got %h lat %0d want %h lat %0d", a, b, res, lat, model(a, b), exp_lat(b));
      end
    end
  endtask

  task automatic test_dbz();
    logic [2*W:0] res; int lat, bn, ov; bit to;
    run_op(4'd5, 4'd0, res, lat, bn, ov, to);
    n_cmp++;
    if (to || res !== {4'd15, 4'd5, 1'b1}) begin n_fail++; $display("FAIL dbz_result got %h want %h", res, {4'd15, 4'd5, 1'b1}); end
    n_cmp++;
    if (lat !== 1 || bn !== 0) begin n_fail++; $display("FAIL dbz_timing lat=%0d busy=%0d want lat 1 busy 0", lat, bn); end
    run_op(4'd9, 4'd2, res, lat, bn, ov, to);
    n_cmp++;
    if (to || res !== {4'd4, 4'd1, 1'b0}) begin n_fail++; $display("FAIL dbz_followup got %h want %h", res, {4'd4, 4'd1, 1'b0}); end
  endtask

  task automatic test_ignore_start();
    int dones; logic [2*W:0] res; bit seen;
    dones = 0; seen = 1'b0; res = '0;
    @(posedge clk); #1;
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    A = 4'd2; B = 4'd1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (!seen) res = {Q, R, dbz};
        seen = 1'b1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (res !== model(4'd13, 4'd3)) begin n_fail++; $display("FAIL ignore_start_result got %h want %h", res, model(4'd13, 4'd3)); end
    n_cmp++;
    if (dones !== 1) begin n_fail++; $display("FAIL ignore_start_dones got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    int dones; logic [2*W:0] res; int lat, bn, ov; bit to;
    @(posedge clk); #1;
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, Q, R, dbz} !== '0) begin n_fail++; $display("FAIL reset_mid_outputs busy=%0b done=%0b Q=%0d R=%0d dbz=%0b want 0", busy, done, Q, R, dbz); end
    #4 rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d want 0", dones); end
    run_op(4'd8, 4'd2, res, lat, bn, ov, to);
    n_cmp++;
    if (to || res !== {4'd4, 4'd0, 1'b0}) begin n_fail++; $display("FAIL reset_mid_followup got %h want %h", res, {4'd4, 4'd0, 1'b0}); end
  endtask

  // All 256 pairs with start held high: each new operand pair is presented
  // in the done cycle of the previous one.
  task automatic test_sweep();
    int gap, want;
    logic [W-1:0] ea, eb;
    @(posedge clk); #1;
    start = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      ea = W'(idx >> 4);
      eb = W'(idx & 15);
      A = ea; B = eb;
      want = (idx == 0) ? exp_lat(eb) : exp_lat(eb) + 1;
      gap = 0;
      do begin
        @(posedge clk); #1;
        gap++;
      end while (!done && gap <= 40);
      n_cmp++;
      if (!done || {Q, R, dbz} !== model(ea, eb) || gap !== want) begin
        n_fail++;
        $display("FAIL sweep_%0d_%0d got %h gap %0d want %h gap %0d", ea, eb, {Q, R, dbz}, gap, model(ea, eb), want);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    logic [2*W:0] res; int lat, bn, ov; bit to;
    logic [W-1:0] a, b;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(a, b, res, lat, bn, ov, to);
      n_cmp++;
      if (to || res !== model(a, b) || lat !== exp_lat(b) || ov !== 0) begin
        n_fail++;
        $display("FAIL random_%0d_%0d got %h lat %0d ov %0d want %h lat %0d", a, b, res, lat, ov, model(a, b), exp_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_dbz();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
